// File: rtl/mdr_unit.sv
// rtl/mdr_unit.sv - Memory Data Register with bounded memory request/acknowledge engine
//
// Holds the MDR value driven onto the bus mux and runs single outstanding
// memory reads (memory -> MDR) and writes (MDR -> memory). A wait counter
// aborts a transaction that never gets acknowledged so the datapath cannot hang.
//
// Ports:
//   clock         system clock, rising edge
//   clear         asynchronous active-low reset
//   BusMuxOut     bus value, loaded into the MDR on a bus load
//   MDRin, Read   load command; Read=1 starts a memory read, Read=0 loads from bus
//   mem_write     start a memory write of the current MDR value
//   mem_rd_data   memory read data, valid with mem_rd_ack
//   mem_rd_ack    read acknowledge
//   mem_wr_ack    write acknowledge
//   mem_rd_req    registered read request
//   mem_wr_req    registered write request
//   mem_wr_data   write data (always the MDR contents)
//   BusMuxIn_MDR  MDR contents to the bus mux
//   busy          high while a transaction is outstanding
//   done          one-cycle pulse after a transaction completes
//   mem_err       sticky timeout flag, cleared when the next transaction starts

module mdr_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] BusMuxOut,
    input  logic        MDRin,
    input  logic        Read,
    input  logic        mem_write,
    input  logic [31:0] mem_rd_data,
    input  logic        mem_rd_ack,
    input  logic        mem_wr_ack,
    output logic        mem_rd_req,
    output logic        mem_wr_req,
    output logic [31:0] mem_wr_data,
    output logic [31:0] BusMuxIn_MDR,
    output logic        busy,
    output logic        done,
    output logic        mem_err
);

    // A zero TIMEOUT still needs a 1-bit counter to keep the code legal.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     mdr_q, mdr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            ack;
    logic            expire;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
            mdr_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mdr_q   <= mdr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Only the ack matching the current wait state counts; the other is stray.
    assign ack = (state_q == RD_WAIT) ? mem_rd_ack : mem_wr_ack;

    // Abort on the edge where this ack-less cycle brings the count to TIMEOUT.
    assign expire = (TIMEOUT > 0) && ((32'(cnt_q) + 32'd1) >= TIMEOUT);

    always_comb begin
        state_d = state_q;
        mdr_d   = mdr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (MDRin && !Read) begin
                    mdr_d = BusMuxOut;
                end else if (MDRin && Read) begin
                    state_d = RD_WAIT;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                end else if (mem_write) begin
                    state_d = WR_WAIT;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (ack) begin
                    if (state_q == RD_WAIT) begin
                        mdr_d = mem_rd_data;
                    end
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (expire) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q != {CW{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_rd_req   = (state_q == RD_WAIT);
    assign mem_wr_req   = (state_q == WR_WAIT);
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign mem_err      = err_q;
    assign BusMuxIn_MDR = mdr_q;
    assign mem_wr_data  = mdr_q;

endmodule

// File: doc/mdr_unit.md
# mdr_unit

Memory Data Register with a memory-side request/acknowledge engine. Drives the `BusMuxIn_MDR` input of the 32-to-1 bus multiplexer and captures the bus output (`BusMuxOut`) for bus-to-MDR transfers. It performs multi-cycle memory reads into the MDR and memory writes from the MDR, with a bounded wait so a dead memory cannot hang the datapath.

## Interface
- `TIMEOUT`, 255: ack-less cycles tolerated in a wait state before abort; 0 disables the timeout.
- `clock`  in  1  system clock, rising-edge.
- `clear`  in  1  asynchronous, active-low reset.
- `BusMuxOut`  in  32  bus value; loaded into the MDR on a bus load.
- `MDRin`  in  1  load command; the source is selected by `Read`.
- `Read`  in  1  with `MDRin`: 1 = load from memory, 0 = load from bus.
- `mem_write`  in  1  start a memory write of the current MDR value.
- `mem_rd_data`  in  32  read data from memory; valid when `mem_rd_ack`=1.
- `mem_rd_ack`  in  1  read acknowledge.
- `mem_wr_ack`  in  1  write acknowledge.
- `mem_rd_req`  out  1  read request, registered.
- `mem_wr_req`  out  1  write request, registered.
- `mem_wr_data`  out  32  equals `BusMuxIn_MDR` at all times.
- `BusMuxIn_MDR`  out  32  MDR contents to the bus mux.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse after a memory transaction completes.
- `mem_err`  out  1  sticky timeout flag; cleared when the next memory operation starts.

## Operation
- States: IDLE, RD_WAIT, WR_WAIT.
- **IDLE, bus load** (`MDRin`=1, `Read`=0): MDR <= `BusMuxOut` on the edge. No state change, no `done`.
- **IDLE, read start** (`MDRin`=1, `Read`=1): go to RD_WAIT, set `mem_rd_req`=1, clear `mem_err`, zero the timeout counter.
- **IDLE, write start** (`mem_write`=1, `MDRin`=0): go to WR_WAIT, set `mem_wr_req`=1, clear `mem_err`, zero the counter.
- **IDLE, `MDRin` and `mem_write` together**: `MDRin` wins and `mem_write` is dropped.
- **RD_WAIT, `mem_rd_ack`=1 sampled**: MDR <= `mem_rd_data`, `mem_rd_req`=0, `done`=1 for the next cycle, go to IDLE.
- **WR_WAIT, `mem_wr_ack`=1 sampled**: `mem_wr_req`=0, `done`=1 for the next cycle, go to IDLE. The MDR is unchanged.
- **Timeout**: in RD_WAIT or WR_WAIT, each ack-less edge increments the counter. The counter is `$clog2(TIMEOUT+1)` bits wide and saturating.
  - When the count reaches `TIMEOUT` (TIMEOUT>0): drop the request, set `mem_err`=1, go to IDLE.
  - On abort the MDR is unchanged and `done` stays 0.
- **Ack on the same edge the count would reach `TIMEOUT`**: the ack wins and the transaction completes normally.
- **Commands while busy**: `MDRin` and `mem_write` are ignored in RD_WAIT and WR_WAIT. The MDR cannot be bus-loaded mid-transaction.
- **Stray acks**: acks in IDLE, or an ack of the wrong type for the current wait state, are ignored.
- **Back-to-back**: a new command may be sampled on the edge after the return to IDLE, i.e. the same cycle `done` is high.

## Timing
- **Reset** (`clear`=0, asynchronous): MDR=0, state=IDLE, counter=0. `mem_rd_req`, `mem_wr_req`, `busy`, `done`, `mem_err` are all 0. The request drops immediately, even mid-transaction.
- **Bus load latency**: `BusMuxIn_MDR` shows the new value one edge after `MDRin` is sampled.
- **Read latency**:
  - Command edge E0 → `mem_rd_req` and `busy` high after E0.
  - Ack sampled at edge En (n≥1) → MDR valid and `done` high after En, `busy` low after En.
  - Minimum read latency is 2 edges, with ack tied high.
- **Request hold**: the request stays high continuously from start to ack or abort; it never deasserts early.

## Test plan
- Bus load: `BusMuxOut`=0xDEADBEEF, `MDRin`=1, `Read`=0 for 1 cycle → `BusMuxIn_MDR`=0xDEADBEEF next cycle, `busy`=0, `done`=0.
- Read: `MDRin`=1, `Read`=1; ack 3 cycles later with `mem_rd_data`=0x12345678 → `mem_rd_req` high for exactly 3 cycles, MDR=0x12345678, `done` single-cycle pulse.
- Write: MDR=0xA5A5A5A5, `mem_write`=1; ack after 1 cycle → `mem_wr_req` high 1 cycle, `mem_wr_data`=0xA5A5A5A5, `done` pulse, MDR unchanged.
- Timeout with `TIMEOUT`=4: read start, no ack → request high 4 cycles, then `mem_err`=1, MDR unchanged.
- Timeout recovery: after the timeout case above, the next read clears `mem_err` and completes normally.
- Command while busy: `MDRin`=1, `Read`=0, `BusMuxOut`=0xFFFFFFFF during RD_WAIT → ignored; MDR ends with the read data.
- Reset mid-read: assert `clear`=0 in RD_WAIT → `mem_rd_req` and `busy` drop without waiting for a clock edge, MDR=0.
- Priority: `MDRin`=1 and `mem_write`=1 in the same cycle in IDLE → the bus load occurs and `mem_wr_req` stays 0.
